// File: rtl/ctrl_pipe_hazard.sv
// ctrl_pipe_hazard
//   Takes the decoded control word and register fields from ID and carries
//   them through the EX, MEM and WB control registers. It also does three
//   other jobs:
//   - detects load-use hazards (stall plus bubble) and taken branches (flush),
//   - produces the EX operand forwarding selects,
//   - keeps saturating stall and flush event counters.
//
// Ports
//   clk, rst                  clock, asynchronous active-high reset
//   id_*                      decoded instruction currently in ID
//   ex_zero                   ALU zero flag of the instruction in EX
//   stall, flush              hold PC and IF/ID / squash IF/ID
//   ex_alu_src, ex_alu_op,
//   ex_rs, ex_rt              EX control and operand addresses
//   fwd_a, fwd_b              2'b00 regfile, 2'b10 MEM result, 2'b01 WB result
//   mem_read, mem_write       MEM-stage control
//   wb_reg_write,
//   wb_mem_to_reg, wb_dest    write-back control
//   stall_cnt, flush_cnt      saturating event counters
module ctrl_pipe_hazard #(
  parameter int RA_W  = 5,
  parameter int AOP_W = 3,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic             id_reg_dst,
  input  logic             id_alu_src,
  input  logic             id_mem_to_reg,
  input  logic             id_reg_write,
  input  logic             id_mem_read,
  input  logic             id_mem_write,
  input  logic             id_branch,
  input  logic [AOP_W-1:0] id_alu_op,
  input  logic [RA_W-1:0]  id_rs,
  input  logic [RA_W-1:0]  id_rt,
  input  logic [RA_W-1:0]  id_rd,
  input  logic             ex_zero,
  output logic             stall,
  output logic             flush,
  output logic             ex_alu_src,
  output logic [AOP_W-1:0] ex_alu_op,
  output logic [RA_W-1:0]  ex_rs,
  output logic [RA_W-1:0]  ex_rt,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             mem_read,
  output logic             mem_write,
  output logic             wb_reg_write,
  output logic             wb_mem_to_reg,
  output logic [RA_W-1:0]  wb_dest,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  // EX stage registers
  logic             exValid, exRegWrite, exMemToReg, exMemRead, exMemWrite;
  logic             exBranch, exAluSrc;
  logic [AOP_W-1:0] exAluOp;
  logic [RA_W-1:0]  exRs, exRt, exDest;
  // MEM stage registers
  logic             memValid, memRegWrite, memMemToReg, memMemRead, memMemWrite;
  logic [RA_W-1:0]  memDest;
  // WB stage registers
  logic             wbValid, wbRegWrite, wbMemToReg;
  logic [RA_W-1:0]  wbDest;
  // Counters
  logic [CNT_W-1:0] stallCnt, flushCnt;

  logic            rtUsed, loadUse, taken, exBubble;
  logic [RA_W-1:0] idDest;

  assign idDest = id_reg_dst ? id_rd : id_rt;
  assign rtUsed = !id_alu_src | id_mem_write | id_branch;

  assign loadUse = id_valid & exValid & exMemRead & (exDest != '0)
                 & ((exDest == id_rs) | (rtUsed & (exDest == id_rt)));
  assign taken   = exValid & exBranch & ex_zero;

  // A taken branch squashes the stalled consumer anyway, so flush wins.
  assign flush    = taken;
  assign stall    = loadUse & !taken;
  assign exBubble = loadUse | taken | !id_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exValid     <= 1'b0;
      exRegWrite  <= 1'b0;
      exMemToReg  <= 1'b0;
      exMemRead   <= 1'b0;
      exMemWrite  <= 1'b0;
      exBranch    <= 1'b0;
      exAluSrc    <= 1'b0;
      exAluOp     <= '0;
      exRs        <= '0;
      exRt        <= '0;
      exDest      <= '0;
      memValid    <= 1'b0;
      memRegWrite <= 1'b0;
      memMemToReg <= 1'b0;
      memMemRead  <= 1'b0;
      memMemWrite <= 1'b0;
      memDest     <= '0;
      wbValid     <= 1'b0;
      wbRegWrite  <= 1'b0;
      wbMemToReg  <= 1'b0;
      wbDest      <= '0;
      stallCnt    <= '0;
      flushCnt    <= '0;
    end else begin
      // Bubbles load all-zero fields, so a bubble never matches a forwarding source.
      if (exBubble) begin
        exValid    <= 1'b0;
        exRegWrite <= 1'b0;
        exMemToReg <= 1'b0;
        exMemRead  <= 1'b0;
        exMemWrite <= 1'b0;
        exBranch   <= 1'b0;
        exAluSrc   <= 1'b0;
        exAluOp    <= '0;
        exRs       <= '0;
        exRt       <= '0;
        exDest     <= '0;
      end else begin
        exValid    <= 1'b1;
        exRegWrite <= id_reg_write;
        exMemToReg <= id_mem_to_reg;
        exMemRead  <= id_mem_read;
        exMemWrite <= id_mem_write;
        exBranch   <= id_branch;
        exAluSrc   <= id_alu_src;
        exAluOp    <= id_alu_op;
        exRs       <= id_rs;
        exRt       <= id_rt;
        exDest     <= idDest;
      end

      // The branch in EX itself always moves on to MEM.
      memValid    <= exValid;
      memRegWrite <= exRegWrite;
      memMemToReg <= exMemToReg;
      memMemRead  <= exMemRead;
      memMemWrite <= exMemWrite;
      memDest     <= exDest;

      wbValid     <= memValid;
      wbRegWrite  <= memRegWrite;
      wbMemToReg  <= memMemToReg;
      wbDest      <= memDest;

      if (stall && (stallCnt != '1)) stallCnt <= stallCnt + CNT_W'(1);
      if (flush && (flushCnt != '1)) flushCnt <= flushCnt + CNT_W'(1);
    end
  end

  // Forwarding: the younger MEM result takes priority over WB.
  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (memValid && memRegWrite && (memDest != '0) && (memDest == exRs))
      fwd_a = 2'b10;
    else if (wbValid && wbRegWrite && (wbDest != '0) && (wbDest == exRs))
      fwd_a = 2'b01;
    if (memValid && memRegWrite && (memDest != '0) && (memDest == exRt))
      fwd_b = 2'b10;
    else if (wbValid && wbRegWrite && (wbDest != '0) && (wbDest == exRt))
      fwd_b = 2'b01;
  end

  // Stage outputs are qualified by valid so a bubble drives zeros.
  assign ex_alu_src    = exValid & exAluSrc;
  assign ex_alu_op     = exValid ? exAluOp : '0;
  assign ex_rs         = exValid ? exRs : '0;
  assign ex_rt         = exValid ? exRt : '0;
  assign mem_read      = memValid & memMemRead;
  assign mem_write     = memValid & memMemWrite;
  assign wb_reg_write  = wbValid & wbRegWrite & (wbDest != '0);
  assign wb_mem_to_reg = wbValid & wbMemToReg;
  assign wb_dest       = wbValid ? wbDest : '0;
  assign stall_cnt     = stallCnt;
  assign flush_cnt     = flushCnt;

endmodule

// File: tb/tb_ctrl_pipe_hazard.sv
// Directed testbench for ctrl_pipe_hazard. The counters are built narrow here
// (CNT_W = 5) so that saturation at all-ones can be reached in a few cycles:
// at most one stall can occur every two clocks.
module tb_ctrl_pipe_hazard;
  localparam int RA_W  = 5;
  localparam int AOP_W = 3;
  localparam int CNT_W = 5;

  logic             clk = 1'b0;
  logic             rst;
  logic             id_valid, id_reg_dst, id_alu_src, id_mem_to_reg;
  logic             id_reg_write, id_mem_read, id_mem_write, id_branch;
  logic [AOP_W-1:0] id_alu_op;
  logic [RA_W-1:0]  id_rs, id_rt, id_rd;
  logic             ex_zero;
  logic             stall, flush, ex_alu_src;
  logic [AOP_W-1:0] ex_alu_op;
  logic [RA_W-1:0]  ex_rs, ex_rt;
  logic [1:0]       fwd_a, fwd_b;
  logic             mem_read, mem_write, wb_reg_write, wb_mem_to_reg;
  logic [RA_W-1:0]  wb_dest;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  int asserts  = 0;
  int failures = 0;

  ctrl_pipe_hazard #(.RA_W(RA_W), .AOP_W(AOP_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_reg_dst(id_reg_dst), .id_alu_src(id_alu_src),
    .id_mem_to_reg(id_mem_to_reg), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .id_branch(id_branch),
    .id_alu_op(id_alu_op), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .ex_zero(ex_zero), .stall(stall), .flush(flush), .ex_alu_src(ex_alu_src),
    .ex_alu_op(ex_alu_op), .ex_rs(ex_rs), .ex_rt(ex_rt), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .mem_read(mem_read), .mem_write(mem_write), .wb_reg_write(wb_reg_write),
    .wb_mem_to_reg(wb_mem_to_reg), .wb_dest(wb_dest),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1);
  end

  // Field order: valid, reg_dst, alu_src, mem_to_reg, reg_write, mem_read,
  // mem_write, branch, alu_op, rs, rt, rd
  task automatic setId(input logic v, input logic rdSel, input logic src, input logic m2r,
                       input logic rw, input logic mr, input logic mw, input logic br,
                       input logic [AOP_W-1:0] op, input logic [RA_W-1:0] rs,
                       input logic [RA_W-1:0] rt, input logic [RA_W-1:0] rd);
    id_valid = v; id_reg_dst = rdSel; id_alu_src = src; id_mem_to_reg = m2r;
    id_reg_write = rw; id_mem_read = mr; id_mem_write = mw; id_branch = br;
    id_alu_op = op; id_rs = rs; id_rt = rt; id_rd = rd;
  endtask

  task automatic idle();
    setId(0, 0, 0, 0, 0, 0, 0, 0, 3'd0, 5'd0, 5'd0, 5'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    idle();
    ex_zero = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    ex_zero = 1'b0;
    repeat (2) tick();
    asserts++; if (stall !== 1'b0) begin failures++; $display("FAIL reset_stall: got %b want 0", stall); end
    asserts++; if (flush !== 1'b0) begin failures++; $display("FAIL reset_flush: got %b want 0", flush); end
    asserts++; if ({fwd_a, fwd_b} !== 4'b0000) begin failures++; $display("FAIL reset_fwd: got %b want 0000", {fwd_a, fwd_b}); end
    asserts++; if ({mem_read, mem_write, wb_reg_write, wb_mem_to_reg} !== 4'b0000) begin failures++; $display("FAIL reset_ctrl: got %b want 0000", {mem_read, mem_write, wb_reg_write, wb_mem_to_reg}); end
    asserts++; if ({stall_cnt, flush_cnt} !== '0) begin failures++; $display("FAIL reset_cnt: got %h/%h want 0/0", stall_cnt, flush_cnt); end
    rst = 1'b0;
    tick();
  endtask

  // lw $2,0($1) ; add $3,$2,$4
  task automatic test_load_use();
    setId(1, 0, 1, 1, 1, 1, 0, 0, 3'd0, 5'd1, 5'd2, 5'd0);
    tick();
    setId(1, 1, 0, 0, 1, 0, 0, 0, 3'd2, 5'd2, 5'd4, 5'd3);
    #1;
    asserts++; if (stall !== 1'b1) begin failures++; $display("FAIL loaduse_stall: got %b want 1", stall); end
    asserts++; if (ex_alu_src !== 1'b1) begin failures++; $display("FAIL loaduse_ex_alu_src: got %b want 1", ex_alu_src); end
    tick();
    asserts++; if (stall !== 1'b0) begin failures++; $display("FAIL loaduse_stall_once: got %b want 0", stall); end
    asserts++; if (ex_rs !== 5'd0 || ex_alu_op !== 3'd0) begin failures++; $display("FAIL loaduse_bubble: got rs=%0d op=%0d want 0/0", ex_rs, ex_alu_op); end
    asserts++; if (mem_read !== 1'b1) begin failures++; $display("FAIL loaduse_mem_read: got %b want 1", mem_read); end
    asserts++; if (stall_cnt !== 5'd1) begin failures++; $display("FAIL loaduse_stall_cnt: got %0d want 1", stall_cnt); end
    tick();
    idle();
    #1;
    asserts++; if (ex_rs !== 5'd2) begin failures++; $display("FAIL loaduse_ex_rs: got %0d want 2", ex_rs); end
    asserts++; if (fwd_a !== 2'b01 || fwd_b !== 2'b00) begin failures++; $display("FAIL loaduse_fwd: got %b/%b want 01/00", fwd_a, fwd_b); end
    asserts++; if (wb_reg_write !== 1'b1 || wb_dest !== 5'd2 || wb_mem_to_reg !== 1'b1) begin failures++; $display("FAIL loaduse_wb: got we=%b dest=%0d m2r=%b want 1/2/1", wb_reg_write, wb_dest, wb_mem_to_reg); end
    drain();
  endtask

  // add $2 ; sub $7,$2,$2 with 0 / 1 gap, and two writers of $2
  task automatic test_forwarding();
    setId(1, 1, 0, 0, 1, 0, 0, 0, 3'd2, 5'd5, 5'd6, 5'd2);
    tick();
    setId(1, 1, 0, 0, 1, 0, 0, 0, 3'd6, 5'd2, 5'd2, 5'd7);
    #1;
    asserts++; if (stall !== 1'b0) begin failures++; $display("FAIL fwd_no_stall: got %b want 0", stall); end
    tick();
    idle();
    #1;
    asserts++; if (fwd_a !== 2'b10 || fwd_b !== 2'b10) begin failures++; $display("FAIL fwd_mem: got %b/%b want 10/10", fwd_a, fwd_b); end
    drain();

    setId(1, 1, 0, 0, 1, 0, 0, 0, 3'd2, 5'd5, 5'd6, 5'd2);
    tick();
    setId(1, 1, 0, 0, 1, 0, 0, 0, 3'd3, 5'd9, 5'd10, 5'd8);
    tick();
    setId(1, 1, 0, 0, 1, 0, 0, 0, 3'd6, 5'd2, 5'd2, 5'd7);
    tick();
    idle();
    #1;
    asserts++; if (fwd_a !== 2'b01 || fwd_b !== 2'b01) begin failures++; $display("FAIL fwd_wb: got %b/%b want 01/01", fwd_a, fwd_b); end
    drain();

    setId(1, 1, 0, 0, 1, 0, 0, 0, 3'd2, 5'd5, 5'd6, 5'd2);
    tick();
    setId(1, 1, 0, 0, 1, 0, 0, 0, 3'd2, 5'd7, 5'd7, 5'd2);
    tick();
    setId(1, 1, 0, 0, 1, 0, 0, 0, 3'd6, 5'd2, 5'd2, 5'd7);
    tick();
    idle();
    #1;
    asserts++; if (fwd_a !== 2'b10 || fwd_b !== 2'b10) begin failures++; $display("FAIL fwd_priority: got %b/%b want 10/10", fwd_a, fwd_b); end
    drain();
  endtask

  task automatic test_branch();
    // Taken beq $1,$3: the instruction behind it is squashed.
    setId(1, 0, 0, 0, 0, 0, 0, 1, 3'd1, 5'd1, 5'd3, 5'd0);
    tick();
    setId(1, 1, 0, 0, 1, 0, 0, 0, 3'd2, 5'd3, 5'd5, 5'd4);
    ex_zero = 1'b1;
    #1;
    asserts++; if (flush !== 1'b1 || stall !== 1'b0) begin failures++; $display("FAIL branch_taken: got flush=%b stall=%b want 1/0", flush, stall); end
    tick();
    ex_zero = 1'b0;
    idle();
    #1;
    asserts++; if (flush !== 1'b0) begin failures++; $display("FAIL branch_flush_once: got %b want 0", flush); end
    asserts++; if (ex_rs !== 5'd0 || ex_alu_op !== 3'd0) begin failures++; $display("FAIL branch_bubble: got rs=%0d op=%0d want 0/0", ex_rs, ex_alu_op); end
    asserts++; if (flush_cnt !== 5'd1) begin failures++; $display("FAIL branch_flush_cnt: got %0d want 1", flush_cnt); end
    drain();

    // Not-taken branch: the follower enters EX.
    setId(1, 0, 0, 0, 0, 0, 0, 1, 3'd1, 5'd1, 5'd3, 5'd0);
    tick();
    setId(1, 1, 0, 0, 1, 0, 0, 0, 3'd2, 5'd3, 5'd5, 5'd4);
    #1;
    asserts++; if (flush !== 1'b0) begin failures++; $display("FAIL branch_not_taken: got %b want 0", flush); end
    tick();
    idle();
    #1;
    asserts++; if (ex_rs !== 5'd3) begin failures++; $display("FAIL branch_follower: got rs=%0d want 3", ex_rs); end
    drain();

    // Branch word that also reads memory into $3, with a $3 consumer in ID:
    // hazard and taken branch coincide, and the flush wins.
    setId(1, 0, 0, 0, 0, 1, 0, 1, 3'd1, 5'd1, 5'd3, 5'd0);
    tick();
    setId(1, 1, 0, 0, 1, 0, 0, 0, 3'd2, 5'd3, 5'd5, 5'd4);
    ex_zero = 1'b1;
    #1;
    asserts++; if (flush !== 1'b1 || stall !== 1'b0) begin failures++; $display("FAIL branch_vs_hazard: got flush=%b stall=%b want 1/0", flush, stall); end
    tick();
    ex_zero = 1'b0;
    idle();
    #1;
    asserts++; if (flush_cnt !== 5'd2 || stall_cnt !== 5'd1) begin failures++; $display("FAIL branch_counts: got flush=%0d stall=%0d want 2/1", flush_cnt, stall_cnt); end
    drain();
  endtask

  task automatic test_zero_reg();
    // addi $0,$1,5 ; add $3,$0,$0
    setId(1, 0, 1, 0, 1, 0, 0, 0, 3'd1, 5'd1, 5'd0, 5'd0);
    tick();
    setId(1, 1, 0, 0, 1, 0, 0, 0, 3'd2, 5'd0, 5'd0, 5'd3);
    #1;
    asserts++; if (stall !== 1'b0) begin failures++; $display("FAIL zero_no_stall: got %b want 0", stall); end
    tick();
    idle();
    #1;
    asserts++; if (fwd_a !== 2'b00 || fwd_b !== 2'b00) begin failures++; $display("FAIL zero_no_fwd: got %b/%b want 00/00", fwd_a, fwd_b); end
    tick();
    asserts++; if (wb_reg_write !== 1'b0) begin failures++; $display("FAIL zero_wb_suppress: got %b want 0", wb_reg_write); end
    drain();

    // lw $0,0($1) ; add $3,$0,$0 must not stall either.
    setId(1, 0, 1, 1, 1, 1, 0, 0, 3'd0, 5'd1, 5'd0, 5'd0);
    tick();
    setId(1, 1, 0, 0, 1, 0, 0, 0, 3'd2, 5'd0, 5'd0, 5'd3);
    #1;
    asserts++; if (stall !== 1'b0) begin failures++; $display("FAIL zero_load_no_stall: got %b want 0", stall); end
    drain();
  endtask

  task automatic test_reset_midstream();
    setId(1, 0, 1, 1, 1, 1, 0, 0, 3'd0, 5'd1, 5'd2, 5'd0);
    tick();
    idle();
    tick();
    asserts++; if (mem_read !== 1'b1) begin failures++; $display("FAIL midrst_pre_mem_read: got %b want 1", mem_read); end
    #2;
    rst = 1'b1;
    #1;
    asserts++; if ({mem_read, mem_write, wb_reg_write, wb_mem_to_reg, ex_alu_src} !== 5'b00000) begin failures++; $display("FAIL midrst_ctrl: got %b want 00000", {mem_read, mem_write, wb_reg_write, wb_mem_to_reg, ex_alu_src}); end
    asserts++; if (wb_dest !== 5'd0 || {stall_cnt, flush_cnt} !== '0) begin failures++; $display("FAIL midrst_state: got dest=%0d cnt=%0d/%0d want 0/0/0", wb_dest, stall_cnt, flush_cnt); end
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      asserts++; if (wb_reg_write !== 1'b0) begin failures++; $display("FAIL midrst_no_wb cycle %0d: got %b want 0", i, wb_reg_write); end
    end
  endtask

  // Hold lw $2,0($2) in ID: every other cycle is a load-use stall.
  task automatic test_saturation();
    setId(1, 0, 1, 1, 1, 1, 0, 0, 3'd0, 5'd2, 5'd2, 5'd0);
    tick();
    for (int i = 0; i < 30; i++) begin
      asserts++; if (stall !== 1'b1) begin failures++; $display("FAIL sat_stall %0d: got %b want 1", i, stall); end
      tick();
      tick();
    end
    asserts++; if (stall_cnt !== 5'h1E) begin failures++; $display("FAIL sat_preload: got %h want 1e", stall_cnt); end
    for (int i = 0; i < 3; i++) begin
      tick();
      tick();
    end
    asserts++; if (stall_cnt !== 5'h1F) begin failures++; $display("FAIL sat_hold: got %h want 1f", stall_cnt); end
    drain();
  endtask

  initial begin
    rst = 1'b1;
    ex_zero = 1'b0;
    idle();
    test_reset();
    test_load_use();
    test_forwarding();
    test_branch();
    test_zero_reg();
    test_reset_midstream();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
    $finish;
  end
endmodule
